mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Requester-side controller that drives the data-memory RAM port on behalf of the core's load/store unit. Converts byte-addressed load/store requests of byte, halfword or word size into word-wide RAM reads and writes. Performs sign/zero extension on loads and read-modify-write for sub-word stores. Sits between the execute stage and the dual-port data RAM (1-cycle registered read latency, same-address write-to-read forwarding).

## Interface
- DW, 32, data width; only 32 is supported
- ADDR_BIT, 12, RAM word-address width; byte address is ADDR_BIT+2 bits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller accepts request this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_BIT+2  byte address
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal-size request
- ram_wen_o  out  1  RAM write strobe
- ram_waddr_o  out  ADDR_BIT  RAM write word address
- ram_wdata_o  out  32  RAM write data
- ram_ren_o  out  1  RAM read strobe
- ram_raddr_o  out  ADDR_BIT  RAM read word address
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_ren_o

## Operation
- States: IDLE, LD_WAIT, RMW. req_ready_o = (state==IDLE) && !rst.
- Accept = req_valid_i && req_ready_o. Word address = req_addr_i[ADDR_BIT+1:2]; lane = req_addr_i[1:0].
- Error check at accept: size 11, half with addr[0]=1, word with addr[1:0]!=0 → no RAM strobe, rsp_err_o=1, rsp_rdata_o=0, stay IDLE.
- Load: ram_ren_o combinationally at accept; capture size/lane/unsigned; → LD_WAIT. In LD_WAIT select byte (lane) or half (addr[1]) from ram_rdata_i, extend per req_unsigned_i, register into rsp_rdata_o, set rsp_valid_o; → IDLE.
- Word store: ram_wen_o with req_wdata_i combinationally at accept; rsp_valid_o next cycle; stay IDLE.
- Byte/half store: ram_ren_o at accept; capture address, lane, size, wdata; → RMW. In RMW ram_wen_o=1 to captured address, ram_wdata_o = ram_rdata_i with target lane(s) replaced by wdata[7:0] or wdata[15:0]; rsp_valid_o next cycle; → IDLE.
- ram_raddr_o/ram_waddr_o come from live request in IDLE, captured address in RMW; 0 when corresponding strobe is low.
- No response backpressure; rsp_valid_o is a pulse the consumer must sample.
- RMW never overlaps another request, so no RAM read/write address hazard arises.

## Timing
- Reset: state IDLE; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; all ram_* strobes forced 0 while rst high, combinationally.
- Accept in cycle T. Load: ram_ren_o T, data T+1, rsp_valid_o T+2, next accept T+2 (1 per 2 cycles).
- Word store: ram_wen_o T, rsp_valid_o T+1, next accept T+1 (1 per cycle).
- Sub-word store: ram_ren_o T, ram_wen_o T+1, rsp_valid_o T+2, next accept T+2.
- Error: rsp_valid_o+rsp_err_o T+1, next accept T+1.
- rsp_rdata_o and rsp_err_o hold last value outside pulses, except cleared to 0 by reset.
- rst during LD_WAIT/RMW: abort, no RAM write that cycle, no response, IDLE next cycle.
- Address wrap: top word address (all ones) handled normally; no increment anywhere.

## Test plan
- Word store 0xDEADBEEF @0x010, load word @0x010 → ram_wen_o T, rsp_valid_o T+1; load rsp_rdata_o=0xDEADBEEF at T+2.
- Byte loads @0x011 of word 0x8081_F203: signed → 0xFFFFFFF2; unsigned → 0x000000F2; half @0x012 signed → 0xFFFF8081.
- Byte store 0xAA @0x013 over 0x11223344 → RAM read T, write 0xAA223344 at T+1, rsp_valid_o T+2; half store 0x5566 @0x010 → 0xAA225566.
- Misaligned: half @0x001, word @0x002, size 11 → no ram strobes, rsp_err_o=1, rsp_valid_o T+1, rsp_rdata_o=0.
- Back-to-back: word store every cycle for 4 cycles with req_valid_i held → 4 writes, 4 responses; load then store → req_ready_o low at T+1, store accepted T+2.
- Reset asserted in RMW cycle → ram_wen_o=0, no rsp_valid_o, RAM word unchanged, req_ready_o=1 first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller for the data RAM port: handles byte, halfword and word accesses.
// Sub-word loads are extended here, and sub-word stores are done as a read-modify-write.
module mem_access_ctrl #(
    parameter int DW       = 32,
    parameter int ADDR_BIT = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_BIT+1:0]   req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DW-1:0]         req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  ram_wen_o,
    output logic [ADDR_BIT-1:0]   ram_waddr_o,
    output logic [DW-1:0]         ram_wdata_o,
    output logic                  ram_ren_o,
    output logic [ADDR_BIT-1:0]   ram_raddr_o,
    input  logic [DW-1:0]         ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, RMW} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t state, state_next;

    logic                accept;
    logic                misaligned;
    logic                word_store;
    logic [ADDR_BIT-1:0] req_word;

    logic [ADDR_BIT-1:0] cap_addr;
    logic [1:0]          cap_lane;
    logic [1:0]          cap_size;
    logic                cap_unsigned;
    logic [15:0]         cap_wdata;

    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic [DW-1:0]       load_data;
    logic [DW-1:0]       merge_data;

    assign req_word    = req_addr_i[ADDR_BIT+1:2];
    assign req_ready_o = (state == IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;
    assign word_store  = req_we_i && (req_size_i == SZ_WORD);

    always_comb begin
        misaligned = 1'b0;
        case (req_size_i)
            SZ_HALF: misaligned = req_addr_i[0];
            SZ_WORD: misaligned = (req_addr_i[1:0] != 2'b00);
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte = ram_rdata_i[7:0];
        case (cap_lane)
            2'd0: sel_byte = ram_rdata_i[7:0];
            2'd1: sel_byte = ram_rdata_i[15:8];
            2'd2: sel_byte = ram_rdata_i[23:16];
            2'd3: sel_byte = ram_rdata_i[31:24];
            default: sel_byte = ram_rdata_i[7:0];
        endcase
        sel_half = cap_lane[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];

        load_data = ram_rdata_i;
        if (cap_size == SZ_BYTE)
            load_data = {{24{~cap_unsigned & sel_byte[7]}}, sel_byte};
        else if (cap_size == SZ_HALF)
            load_data = {{16{~cap_unsigned & sel_half[15]}}, sel_half};
    end

    // Only the addressed byte lane(s) are replaced; the rest of the word comes from the RAM read.
    always_comb begin
        merge_data = ram_rdata_i;
        if (cap_size == SZ_HALF) begin
            if (cap_lane[1])
                merge_data[31:16] = cap_wdata;
            else
                merge_data[15:0] = cap_wdata;
        end else begin
            case (cap_lane)
                2'd0: merge_data[7:0]   = cap_wdata[7:0];
                2'd1: merge_data[15:8]  = cap_wdata[7:0];
                2'd2: merge_data[23:16] = cap_wdata[7:0];
                2'd3: merge_data[31:24] = cap_wdata[7:0];
                default: merge_data = ram_rdata_i;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        ram_wen_o   = 1'b0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        ram_ren_o   = 1'b0;
        ram_raddr_o = '0;
        case (state)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (word_store) begin
                        ram_wen_o   = 1'b1;
                        ram_waddr_o = req_word;
                        ram_wdata_o = req_wdata_i;
                    end else begin
                        ram_ren_o   = 1'b1;
                        ram_raddr_o = req_word;
                        state_next  = req_we_i ? RMW : LD_WAIT;
                    end
                end
            end
            LD_WAIT: state_next = IDLE;
            RMW: begin
                // A reset arriving here abandons the write.
                if (!rst) begin
                    ram_wen_o   = 1'b1;
                    ram_waddr_o = cap_addr;
                    ram_wdata_o = merge_data;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_addr     <= req_word;
            cap_lane     <= req_addr_i[1:0];
            cap_size     <= req_size_i;
            cap_unsigned <= req_unsigned_i;
            cap_wdata    <= req_wdata_i[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && misaligned) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end else if (accept && word_store) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                    end
                end
                LD_WAIT: begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= load_data;
                end
                RMW: begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: it models the data RAM and uses a response scoreboard.
// The tests check strobe timing cycle by cycle.
module tb_mem_access_ctrl;

    localparam int ADDR_BIT = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_we_i;
    logic [ADDR_BIT+1:0] req_addr_i;
    logic [1:0]          req_size_i;
    logic                req_unsigned_i;
    logic [31:0]         req_wdata_i;
    logic                rsp_valid_o;
    logic [31:0]         rsp_rdata_o;
    logic                rsp_err_o;
    logic                ram_wen_o;
    logic [ADDR_BIT-1:0] ram_waddr_o;
    logic [31:0]         ram_wdata_o;
    logic                ram_ren_o;
    logic [ADDR_BIT-1:0] ram_raddr_o;
    logic [31:0]         ram_rdata_i;

    mem_access_ctrl #(.DW(32), .ADDR_BIT(ADDR_BIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_wen_o(ram_wen_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
        .ram_ren_o(ram_ren_o), .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered read, same-address write forwarded to the read port.
    logic [31:0] mem [0:(1<<ADDR_BIT)-1];
    always @(posedge clk) begin
        if (ram_wen_o) mem[ram_waddr_o] <= ram_wdata_o;
        if (ram_ren_o)
            ram_rdata_i <= (ram_wen_o && ram_waddr_o == ram_raddr_o) ? ram_wdata_o : mem[ram_raddr_o];
    end

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t sb_head;

    always @(negedge clk) begin
        if (rsp_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata_o, rsp_err_o);
            end else begin
                sb_head = exp_q.pop_front();
                if ({rsp_rdata_o, rsp_err_o} !== {sb_head.rdata, sb_head.err}) begin
                    errors++;
                    $display("FAIL rsp: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata_o, rsp_err_o, sb_head.rdata, sb_head.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic we, input logic [13:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic e);
        rsp_t item;
        item.rdata = d;
        item.err   = e;
        exp_q.push_back(item);
    endtask

    task automatic do_load(input logic [13:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] exp_data);
        expect_rsp(exp_data, 1'b0);
        drive(1'b0, addr, size, uns, 32'h0);
        step(); idle(); step();
    endtask

    task automatic do_wstore(input logic [13:0] addr, input logic [31:0] data);
        expect_rsp(32'h0, 1'b0);
        drive(1'b1, addr, 2'b10, 1'b0, data);
        step(); idle();
    endtask

    task automatic do_sstore(input logic [13:0] addr, input logic [1:0] size, input logic [31:0] data);
        expect_rsp(32'h0, 1'b0);
        drive(1'b1, addr, size, 1'b0, data);
        step(); idle(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 14'h010, 2'b10, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready_o, ram_ren_o, ram_wen_o, rsp_valid_o, rsp_err_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {req_ready_o, ram_ren_o, ram_wen_o, rsp_valid_o, rsp_err_o});
        end
        checks++;
        if (rsp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h, required 0", rsp_rdata_o);
        end
        step(); rst = 1'b0; idle();
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", req_ready_o);
        end
        step();
    endtask

    task automatic test_word_store_load();
        expect_rsp(32'h0, 1'b0);
        drive(1'b1, 14'h010, 2'b10, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({ram_wen_o, ram_waddr_o, ram_wdata_o, ram_ren_o, req_ready_o} !== {1'b1, 12'h004, 32'hDEADBEEF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wstore_T: got wen=%b waddr=%h wdata=%h ren=%b, required 1 004 deadbeef 0",
                     ram_wen_o, ram_waddr_o, ram_wdata_o, ram_ren_o);
        end
        step(); idle();
        @(negedge clk);
        checks++;
        if ({rsp_valid_o, ram_wen_o} !== 2'b10) begin
            errors++; $display("FAIL wstore_T1: got valid,wen=%b, required 10", {rsp_valid_o, ram_wen_o});
        end
        step();
        expect_rsp(32'hDEADBEEF, 1'b0);
        drive(1'b0, 14'h010, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({ram_ren_o, ram_raddr_o, ram_wen_o} !== {1'b1, 12'h004, 1'b0}) begin
            errors++;
            $display("FAIL load_T: got ren=%b raddr=%h wen=%b, required 1 004 0", ram_ren_o, ram_raddr_o, ram_wen_o);
        end
        step(); idle();
        @(negedge clk);
        checks++;
        if ({rsp_valid_o, req_ready_o, ram_ren_o} !== 3'b000) begin
            errors++; $display("FAIL load_T1: got valid,ready,ren=%b, required 000", {rsp_valid_o, req_ready_o, ram_ren_o});
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid_o, req_ready_o} !== 2'b11) begin
            errors++; $display("FAIL load_T2: got valid,ready=%b, required 11", {rsp_valid_o, req_ready_o});
        end
        step();
    endtask

    task automatic test_load_extend();
        do_wstore(14'h010, 32'h8081F203);
        do_load(14'h011, 2'b00, 1'b0, 32'hFFFFFFF2);
        do_load(14'h011, 2'b00, 1'b1, 32'h000000F2);
        do_load(14'h012, 2'b01, 1'b0, 32'hFFFF8081);
        do_load(14'h012, 2'b01, 1'b1, 32'h00008081);
        do_load(14'h013, 2'b00, 1'b0, 32'hFFFFFF80);
        do_load(14'h010, 2'b01, 1'b0, 32'hFFFFF203);
        do_load(14'h010, 2'b00, 1'b0, 32'h00000003);
    endtask

    task automatic test_subword_store();
        do_wstore(14'h010, 32'h11223344);
        expect_rsp(32'h0, 1'b0);
        drive(1'b1, 14'h013, 2'b00, 1'b0, 32'hFFFFFFAA);
        @(negedge clk);
        checks++;
        if ({ram_ren_o, ram_raddr_o, ram_wen_o} !== {1'b1, 12'h004, 1'b0}) begin
            errors++;
            $display("FAIL rmw_T: got ren=%b raddr=%h wen=%b, required 1 004 0", ram_ren_o, ram_raddr_o, ram_wen_o);
        end
        step(); idle();
        @(negedge clk);
        checks++;
        if ({ram_wen_o, ram_waddr_o, ram_wdata_o, ram_ren_o, rsp_valid_o, req_ready_o} !==
            {1'b1, 12'h004, 32'hAA223344, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rmw_T1: got wen=%b waddr=%h wdata=%h ren=%b valid=%b ready=%b, required 1 004 aa223344 0 0 0",
                     ram_wen_o, ram_waddr_o, ram_wdata_o, ram_ren_o, rsp_valid_o, req_ready_o);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid_o, ram_wen_o, req_ready_o} !== 3'b101) begin
            errors++; $display("FAIL rmw_T2: got valid,wen,ready=%b, required 101", {rsp_valid_o, ram_wen_o, req_ready_o});
        end
        step();
        do_sstore(14'h010, 2'b01, 32'hFFFF5566);
        do_load(14'h010, 2'b10, 1'b0, 32'hAA225566);
        checks++;
        if (mem[4] !== 32'hAA225566) begin
            errors++; $display("FAIL rmw_mem: got %h, required aa225566", mem[4]);
        end
    endtask

    task automatic test_misaligned();
        logic        ew [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [13:0] ea [6] = '{14'h001, 14'h001, 14'h002, 14'h003, 14'h000, 14'h000};
        logic [1:0]  es [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid_o, rsp_rdata_o} !== {1'b0, 32'hAA225566}) begin
            errors++; $display("FAIL rdata_hold: got valid=%b rdata=%h, required 0 aa225566", rsp_valid_o, rsp_rdata_o);
        end
        step();
        do_wstore(14'h000, 32'h0BADF00D);
        for (int i = 0; i < 6; i++) begin
            expect_rsp(32'h0, 1'b1);
            drive(ew[i], ea[i], es[i], 1'b0, 32'h12345678);
            @(negedge clk);
            checks++;
            if ({ram_ren_o, ram_wen_o, req_ready_o} !== 3'b001) begin
                errors++; $display("FAIL err_strobe%0d: got ren,wen,ready=%b, required 001", i, {ram_ren_o, ram_wen_o, req_ready_o});
            end
            step(); idle();
            @(negedge clk);
            checks++;
            if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
                errors++;
                $display("FAIL err_rsp%0d: got valid=%b err=%b rdata=%h ready=%b, required 1 1 0 1",
                         i, rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid_o, rsp_err_o} !== 2'b01) begin
            errors++; $display("FAIL err_hold: got valid,err=%b, required 01", {rsp_valid_o, rsp_err_o});
        end
        checks++;
        if (mem[0] !== 32'h0BADF00D) begin
            errors++; $display("FAIL err_mem: got %h, required 0badf00d", mem[0]);
        end
        step();
        do_wstore(14'h014, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            expect_rsp(32'h0, 1'b0);
            drive(1'b1, 14'h020 + 14'(4 * i), 2'b10, 1'b0, 32'hB0B00000 + 32'(i));
            @(negedge clk);
            checks++;
            if ({ram_wen_o, ram_waddr_o, ram_wdata_o, req_ready_o} !== {1'b1, 12'h008 + 12'(i), 32'hB0B00000 + 32'(i), 1'b1}) begin
                errors++;
                $display("FAIL b2b_write%0d: got wen=%b waddr=%h wdata=%h ready=%b", i, ram_wen_o, ram_waddr_o, ram_wdata_o, req_ready_o);
            end
            step();
        end
        idle();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[8 + i] !== 32'hB0B00000 + 32'(i)) begin
                errors++; $display("FAIL b2b_mem%0d: got %h, required %h", i, mem[8 + i], 32'hB0B00000 + 32'(i));
            end
        end
        expect_rsp(32'hB0B00000, 1'b0);
        drive(1'b0, 14'h020, 2'b10, 1'b0, 32'h0);
        step();
        expect_rsp(32'h0, 1'b0);
        drive(1'b1, 14'h030, 2'b10, 1'b0, 32'h0C0FFEE0);
        @(negedge clk);
        checks++;
        if ({req_ready_o, ram_wen_o, ram_ren_o} !== 3'b000) begin
            errors++; $display("FAIL ld_st_T1: got ready,wen,ren=%b, required 000", {req_ready_o, ram_wen_o, ram_ren_o});
        end
        step();
        @(negedge clk);
        checks++;
        if ({req_ready_o, ram_wen_o, ram_waddr_o, rsp_valid_o} !== {1'b1, 1'b1, 12'h00C, 1'b1}) begin
            errors++;
            $display("FAIL ld_st_T2: got ready=%b wen=%b waddr=%h valid=%b, required 1 1 00c 1",
                     req_ready_o, ram_wen_o, ram_waddr_o, rsp_valid_o);
        end
        step(); idle();
        step();
    endtask

    task automatic test_addr_wrap();
        expect_rsp(32'h0, 1'b0);
        drive(1'b1, 14'h3FFC, 2'b10, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if ({ram_wen_o, ram_waddr_o} !== {1'b1, 12'hFFF}) begin
            errors++; $display("FAIL wrap_waddr: got wen=%b waddr=%h, required 1 fff", ram_wen_o, ram_waddr_o);
        end
        step(); idle();
        do_load(14'h3FFF, 2'b00, 1'b1, 32'h000000CA);
        do_load(14'h3FFE, 2'b01, 1'b0, 32'hFFFFCAFE);
        checks++;
        if (mem[0] !== 32'h0BADF00D) begin
            errors++; $display("FAIL wrap_mem0: got %h, required 0badf00d", mem[0]);
        end
    endtask

    task automatic test_reset_rmw();
        do_wstore(14'h040, 32'h11223344);
        drive(1'b1, 14'h040, 2'b00, 1'b0, 32'h00000055);
        step(); idle(); rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_wen_o, ram_ren_o, rsp_valid_o, req_ready_o} !== 4'b0000) begin
            errors++; $display("FAIL rst_rmw: got wen,ren,valid,ready=%b, required 0000", {ram_wen_o, ram_ren_o, rsp_valid_o, req_ready_o});
        end
        step(); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rst_after: got ready=%b valid=%b rdata=%h, required 1 0 0", req_ready_o, rsp_valid_o, rsp_rdata_o);
        end
        checks++;
        if (mem[16] !== 32'h11223344) begin
            errors++; $display("FAIL rst_mem: got %h, required 11223344", mem[16]);
        end
        step();
        do_load(14'h040, 2'b10, 1'b0, 32'h11223344);
        step();
    endtask

    initial begin
        rst            = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_addr_i     = '0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_wdata_i    = '0;
        test_reset();
        test_word_store_load();
        test_load_extend();
        test_subword_store();
        test_misaligned();
        test_back_to_back();
        test_addr_wrap();
        test_reset_rmw();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_rsp: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
